// File: rtl/stroke_pkg.sv
// Shared widths, constants and state encoding for the stroke template matcher.
package stroke_pkg;

    localparam int STROKE_W    = 128;
    localparam int LEN_W       = 6;
    localparam int SCORE_W     = 8;
    localparam int N_TEMPL_DEF = 16;
    localparam int TIMEOUT_DEF = 4095;

    localparam logic [SCORE_W-1:0] SCORE_NONE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACCUM  = 3'd4,
        ST_REPORT = 3'd5
    } state_e;

endpackage

// File: rtl/match_best_track.sv
// Running-minimum tracker: keeps the lowest score seen and the index that produced it.
module match_best_track
    import stroke_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_update,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [SCORE_W-1:0] o_best_score,
    output logic [IDX_W-1:0]   o_best_idx
);

    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]   best_idx_q,   best_idx_d;

    // Strict less-than: on equal scores the earlier (lower) index is kept.
    always_comb begin
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        if (i_clear) begin
            best_score_d = SCORE_NONE;
            best_idx_d   = '0;
        end else if (i_update && (i_score < best_score_q)) begin
            best_score_d = i_score;
            best_idx_d   = i_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            best_score_q <= SCORE_NONE;
            best_idx_q   <= '0;
        end else begin
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
        end
    end

    assign o_best_score = best_score_q;
    assign o_best_idx   = best_idx_q;

endmodule

// File: rtl/stroke_match_sched.sv
// Scores one stroke against a template table by sequencing Compare once per template.
// Optional build macro STROKE_EARLY_EXIT_EN: a zero score ends the scan immediately.
module stroke_match_sched
    import stroke_pkg::*;
#(
    parameter int  N_TEMPL = N_TEMPL_DEF,
    parameter int  TIMEOUT = TIMEOUT_DEF,
    localparam int IDX_W   = $clog2(N_TEMPL)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [STROKE_W-1:0] i_stroke,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [IDX_W:0]      i_num_tpl,
    output logic [IDX_W-1:0]    o_tpl_idx,
    input  logic [STROKE_W-1:0] i_tpl_stroke,
    input  logic [LEN_W-1:0]    i_tpl_len,
    output logic                o_cmp_start_n,
    output logic [STROKE_W-1:0] o_cmp_stroke1,
    output logic [STROKE_W-1:0] o_cmp_stroke2,
    output logic [LEN_W-1:0]    o_cmp_len1,
    output logic [LEN_W-1:0]    o_cmp_len2,
    input  logic                i_cmp_done,
    input  logic [SCORE_W-1:0]  i_cmp_score,
    output logic                o_busy,
    output logic                o_valid,
    output logic [IDX_W-1:0]    o_best_idx,
    output logic [SCORE_W-1:0]  o_best_score,
    output logic                o_timeout,
    output logic [2:0]          o_state
);

    localparam int                 CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]     NUM_MAX = (IDX_W + 1)'(N_TEMPL);
    localparam logic [CNT_W-1:0]   CNT_TO  = CNT_W'(TIMEOUT);

    state_e              state_q, state_d;
    logic [STROKE_W-1:0] stroke_q, stroke_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [IDX_W:0]      num_q, num_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                to_q, to_d;
    logic [STROKE_W-1:0] c_stroke1_q, c_stroke1_d, c_stroke2_q, c_stroke2_d;
    logic [LEN_W-1:0]    c_len1_q, c_len1_d, c_len2_q, c_len2_d;
    logic [SCORE_W-1:0]  res_score_q, res_score_d;
    logic [IDX_W-1:0]    res_idx_q, res_idx_d;
    logic                start_n;
    logic                trk_clear, trk_update;
    logic [SCORE_W-1:0]  trk_score;
    logic [IDX_W-1:0]    trk_idx;

    // Compare handshake: start_n is low for exactly the LAUNCH cycle; done is a level
    // that may still be high from the previous run, so it is only trusted from the
    // second WAIT cycle on, and i_cmp_score is taken in the cycle done is accepted.
    always_comb begin
        state_d     = state_q;
        stroke_d    = stroke_q;
        len_d       = len_q;
        num_d       = num_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        to_d        = to_q;
        c_stroke1_d = c_stroke1_q;
        c_stroke2_d = c_stroke2_q;
        c_len1_d    = c_len1_q;
        c_len2_d    = c_len2_q;
        res_score_d = res_score_q;
        res_idx_d   = res_idx_q;
        start_n     = 1'b1;
        trk_clear   = 1'b0;
        trk_update  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    stroke_d  = i_stroke;
                    len_d     = i_len;
                    num_d     = (i_num_tpl > NUM_MAX) ? NUM_MAX : i_num_tpl;
                    idx_d     = '0;
                    to_d      = 1'b0;
                    trk_clear = 1'b1;
                    state_d   = (i_num_tpl == '0) ? ST_REPORT : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                if (i_tpl_len == '0) begin
                    score_d = SCORE_NONE;
                    state_d = ST_ACCUM;
                end else begin
                    c_stroke1_d = stroke_q;
                    c_len1_d    = len_q;
                    c_stroke2_d = i_tpl_stroke;
                    c_len2_d    = i_tpl_len;
                    start_n     = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((cnt_q != '0) && i_cmp_done) begin
                    score_d = i_cmp_score;
                    state_d = ST_ACCUM;
                end else if (cnt_q == CNT_TO) begin
                    to_d    = 1'b1;
                    score_d = SCORE_NONE;
                    state_d = ST_ACCUM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACCUM: begin
                trk_update = 1'b1;
`ifdef STROKE_EARLY_EXIT_EN
                if (score_q == '0) begin
                    state_d = ST_REPORT;
                end else
`endif
                if ({1'b0, idx_q} == (num_q - 1'b1)) begin
                    state_d = ST_REPORT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_REPORT: begin
                res_score_d = trk_score;
                res_idx_d   = trk_idx;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            stroke_q    <= '0;
            len_q       <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            score_q     <= SCORE_NONE;
            to_q        <= 1'b0;
            c_stroke1_q <= '0;
            c_stroke2_q <= '0;
            c_len1_q    <= '0;
            c_len2_q    <= '0;
            res_score_q <= SCORE_NONE;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            stroke_q    <= stroke_d;
            len_q       <= len_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            score_q     <= score_d;
            to_q        <= to_d;
            c_stroke1_q <= c_stroke1_d;
            c_stroke2_q <= c_stroke2_d;
            c_len1_q    <= c_len1_d;
            c_len2_q    <= c_len2_d;
            res_score_q <= res_score_d;
            res_idx_q   <= res_idx_d;
        end
    end

    match_best_track #(.IDX_W(IDX_W)) u_track (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (trk_clear),
        .i_update     (trk_update),
        .i_score      (score_q),
        .i_idx        (idx_q),
        .o_best_score (trk_score),
        .o_best_idx   (trk_idx)
    );

    // The result is presented from the tracker during the o_valid cycle, then held.
    assign o_best_score  = (state_q == ST_REPORT) ? trk_score : res_score_q;
    assign o_best_idx    = (state_q == ST_REPORT) ? trk_idx : res_idx_q;
    assign o_valid       = (state_q == ST_REPORT);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_tpl_idx     = idx_q;
    assign o_timeout     = to_q;
    assign o_cmp_start_n = start_n;
    assign o_cmp_stroke1 = c_stroke1_q;
    assign o_cmp_stroke2 = c_stroke2_q;
    assign o_cmp_len1    = c_len1_q;
    assign o_cmp_len2    = c_len2_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_stroke_match_sched.sv
// Directed table-driven bench for stroke_match_sched with a template ROM and Compare model.
module tb_stroke_match_sched;

  logic         i_clk, i_rst_n, i_start;
  logic [127:0] i_stroke, i_tpl_stroke;
  logic [5:0]   i_len, i_tpl_len;
  logic [4:0]   i_num_tpl;
  logic [3:0]   o_tpl_idx, o_best_idx;
  logic         o_cmp_start_n, i_cmp_done, o_busy, o_valid, o_timeout;
  logic [127:0] o_cmp_stroke1, o_cmp_stroke2;
  logic [5:0]   o_cmp_len1, o_cmp_len2;
  logic [7:0]   i_cmp_score, o_best_score;
  logic [2:0]   o_state;

  stroke_match_sched dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stroke(i_stroke),
    .i_len(i_len), .i_num_tpl(i_num_tpl), .o_tpl_idx(o_tpl_idx),
    .i_tpl_stroke(i_tpl_stroke), .i_tpl_len(i_tpl_len), .o_cmp_start_n(o_cmp_start_n),
    .o_cmp_stroke1(o_cmp_stroke1), .o_cmp_stroke2(o_cmp_stroke2),
    .o_cmp_len1(o_cmp_len1), .o_cmp_len2(o_cmp_len2), .i_cmp_done(i_cmp_done),
    .i_cmp_score(i_cmp_score), .o_busy(o_busy), .o_valid(o_valid),
    .o_best_idx(o_best_idx), .o_best_score(o_best_score), .o_timeout(o_timeout),
    .o_state(o_state)
  );

  typedef struct packed {
    logic [4:0]        num;
    logic [15:0][5:0]  len;
    logic [15:0][7:0]  scr;
    logic [15:0][15:0] dly;       // 0 = Compare never finishes
    logic [3:0]        exp_idx;
    logic [7:0]        exp_score;
    logic              exp_to;
    logic [4:0]        exp_starts;
    logic [3:0]        exp_last;  // last template actually launched
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs[NVEC];

  logic [5:0]   rom_len[16];
  logic [127:0] rom_stroke[16];
  logic [7:0]   rom_scr[16];
  logic [15:0]  rom_dly[16];

  int pass_cnt = 0;
  int total_cnt = 0;
  int valid_cnt = 0;
  int start_cnt = 0;

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ROM (1-cycle latency) and Compare model: done level held, stale in first WAIT cycle.
  initial begin : model
    logic       nstart, active;
    logic [3:0] addr, cur;
    int         k;
    active = 1'b0; cur = '0; k = 0; addr = '0;
    i_tpl_len = '0; i_tpl_stroke = '0; i_cmp_done = 1'b0; i_cmp_score = '0;
    forever begin
      @(negedge i_clk);
      nstart = (o_cmp_start_n == 1'b0);
      addr   = o_tpl_idx;
      if (!i_rst_n) active = 1'b0;
      if (o_valid) valid_cnt++;
      if (nstart) begin start_cnt++; cur = addr; end
      @(posedge i_clk);
      #1;
      i_tpl_len    = rom_len[addr];
      i_tpl_stroke = rom_stroke[addr];
      if (nstart) begin
        active = 1'b1;
        k = 1;
      end else if (active) begin
        k++;
        if (rom_dly[cur] != 0 && k >= int'(rom_dly[cur])) begin
          i_cmp_done  = 1'b1;
          i_cmp_score = rom_scr[cur];
        end else begin
          i_cmp_done = 1'b0;
        end
      end
    end
  end

  function automatic vec_t blank(input logic [4:0] num);
    vec_t v;
    v = '0;
    v.num = num;
    for (int i = 0; i < 16; i++) begin
      v.len[i] = 6'd8;
      v.scr[i] = 8'd100;
      v.dly[i] = 16'd2;
    end
    return v;
  endfunction

  task automatic load_rom(input int v);
    for (int i = 0; i < 16; i++) begin
      rom_len[i]    = vecs[v].len[i];
      rom_scr[i]    = vecs[v].scr[i];
      rom_dly[i]    = vecs[v].dly[i];
      rom_stroke[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_start_n"}, o_cmp_start_n, 1'b1);
    check({tag, "_timeout"}, o_timeout, 1'b0);
    check({tag, "_best_score"}, o_best_score, 8'hFF);
    check({tag, "_best_idx"}, o_best_idx, 4'd0);
    check({tag, "_tpl_idx"}, o_tpl_idx, 4'd0);
    check({tag, "_cmp_s1"}, o_cmp_stroke1, 128'd0);
    check({tag, "_cmp_s2"}, o_cmp_stroke2, 128'd0);
    check({tag, "_cmp_l1"}, o_cmp_len1, 6'd0);
    check({tag, "_cmp_l2"}, o_cmp_len2, 6'd0);
  endtask

  // driver: one full job for vector v, then result checks
  task automatic run_job(input int v);
    logic [127:0] stk;
    logic [5:0]   ln;
    logic         got;
    int           n;
    string        t;
    t = $sformatf("v%0d", v);
    load_rom(v);
    stk = {$urandom, $urandom, $urandom, $urandom};
    ln  = 6'($urandom_range(1, 32));
    @(posedge i_clk); #1;
    valid_cnt = 0; start_cnt = 0;
    i_start = 1'b1; i_stroke = stk; i_len = ln; i_num_tpl = vecs[v].num;
    @(negedge i_clk);
    n = 1; got = o_valid;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_stroke = {$urandom, $urandom, $urandom, $urandom};
    i_len = 6'($urandom_range(0, 63)); i_num_tpl = 5'($urandom_range(0, 31));
    while (!got && n < 20000) begin
      @(negedge i_clk);
      n++;
      got = o_valid;
    end
    check({t, "_valid_seen"}, got, 1'b1);
    if (got) begin
      check({t, "_best_idx"}, o_best_idx, vecs[v].exp_idx);
      check({t, "_best_score"}, o_best_score, vecs[v].exp_score);
      check({t, "_timeout"}, o_timeout, vecs[v].exp_to);
      check({t, "_busy_in_report"}, o_busy, 1'b1);
      if (vecs[v].num == 5'd0) check({t, "_latency"}, n, 2);
    end
    repeat (3) @(negedge i_clk);
    check({t, "_valid_pulses"}, valid_cnt, 1);
    check({t, "_start_pulses"}, start_cnt, vecs[v].exp_starts);
    check({t, "_busy_after"}, o_busy, 1'b0);
    check({t, "_idx_held"}, o_best_idx, vecs[v].exp_idx);
    check({t, "_score_held"}, o_best_score, vecs[v].exp_score);
    if (vecs[v].exp_starts != 0) begin
      check({t, "_cmp_stroke1"}, o_cmp_stroke1, stk);
      check({t, "_cmp_len1"}, o_cmp_len1, ln);
      check({t, "_cmp_stroke2"}, o_cmp_stroke2, rom_stroke[vecs[v].exp_last]);
      check({t, "_cmp_len2"}, o_cmp_len2, rom_len[vecs[v].exp_last]);
    end
  endtask

  initial begin : main
    int n;
    // scores 40, 12, 12: first 12 wins the tie
    vecs[0] = blank(5'd3);
    vecs[0].scr[0] = 8'd40; vecs[0].scr[1] = 8'd12; vecs[0].scr[2] = 8'd12;
    vecs[0].dly[1] = 16'd3;
    vecs[0].exp_idx = 4'd1; vecs[0].exp_score = 8'd12; vecs[0].exp_starts = 5'd3; vecs[0].exp_last = 4'd2;
    // no templates
    vecs[1] = blank(5'd0);
    vecs[1].exp_score = 8'hFF;
    // template 1 skipped (length 0)
    vecs[2] = blank(5'd3);
    vecs[2].scr[0] = 8'd30; vecs[2].len[1] = 6'd0; vecs[2].scr[1] = 8'd1; vecs[2].scr[2] = 8'd50;
    vecs[2].exp_idx = 4'd0; vecs[2].exp_score = 8'd30; vecs[2].exp_starts = 5'd2; vecs[2].exp_last = 4'd2;
    // template 0 times out, template 1 scores 7
    vecs[3] = blank(5'd2);
    vecs[3].dly[0] = 16'd0; vecs[3].scr[0] = 8'd0; vecs[3].scr[1] = 8'd7;
    vecs[3].exp_idx = 4'd1; vecs[3].exp_score = 8'd7; vecs[3].exp_to = 1'b1;
    vecs[3].exp_starts = 5'd2; vecs[3].exp_last = 4'd1;
    // scores 20, 0, 5
    vecs[4] = blank(5'd3);
    vecs[4].scr[0] = 8'd20; vecs[4].scr[1] = 8'd0; vecs[4].scr[2] = 8'd5;
    vecs[4].exp_idx = 4'd1; vecs[4].exp_score = 8'd0;
`ifdef STROKE_EARLY_EXIT_EN
    vecs[4].exp_starts = 5'd2; vecs[4].exp_last = 4'd1;
`else
    vecs[4].exp_starts = 5'd3; vecs[4].exp_last = 4'd2;
`endif
    // three-way tie with differing Compare latencies
    vecs[5] = blank(5'd3);
    vecs[5].scr[0] = 8'd9; vecs[5].scr[1] = 8'd9; vecs[5].scr[2] = 8'd9;
    vecs[5].dly[0] = 16'd4; vecs[5].dly[2] = 16'd3;
    vecs[5].exp_idx = 4'd0; vecs[5].exp_score = 8'd9; vecs[5].exp_starts = 5'd3; vecs[5].exp_last = 4'd2;
    // num_tpl 20 clamped to 16; best is the last template
    vecs[6] = blank(5'd20);
    vecs[6].scr[15] = 8'd3;
    vecs[6].exp_idx = 4'd15; vecs[6].exp_score = 8'd3; vecs[6].exp_starts = 5'd16; vecs[6].exp_last = 4'd15;
    // every template skipped
    vecs[7] = blank(5'd2);
    vecs[7].len[0] = 6'd0; vecs[7].len[1] = 6'd0;
    vecs[7].exp_score = 8'hFF;

    for (int i = 0; i < 16; i++) begin
      rom_len[i] = '0; rom_stroke[i] = '0; rom_scr[i] = '0; rom_dly[i] = '0;
    end
    i_rst_n = 1'b0; i_start = 1'b0; i_stroke = '0; i_len = '0; i_num_tpl = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;

    for (int v = 0; v < NVEC; v++) run_job(v);

    // reset asserted while waiting on Compare
    vecs[0].dly[0] = 16'd60;
    load_rom(0);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_stroke = {$urandom, $urandom, $urandom, $urandom}; i_len = 6'd5; i_num_tpl = 5'd3;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n = 0;
    while (o_state != 3'd3 && n < 50) begin @(negedge i_clk); n++; end
    check("rst_reached_wait", o_state, 3'd3);
    repeat (3) @(negedge i_clk);
    check("rst_cmp_len1_before", o_cmp_len1, 6'd5);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge i_clk);
    check("midrst_state", o_state, 3'd0);
    valid_cnt = 0;
    i_rst_n = 1'b1;
    repeat (20) @(negedge i_clk);
    check("midrst_no_valid", valid_cnt, 0);
    check("midrst_idle", o_busy, 1'b0);
    vecs[0].dly[0] = 16'd2;
    run_job(0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
